// File: rtl/seg_display_ctrl.sv
// Signed binary to multi-digit 7-segment display controller.
// Sequential double-dabble conversion, sign/blanking format, blinking error pattern.
module seg_display_ctrl #(
   parameter int DIGITS    = 4,
   parameter int WIDTH     = 10,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [WIDTH-1:0]      value,
   input  logic                  neg,
   input  logic                  overflow,
   input  logic                  blink_err,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = $clog2(BLINK_DIV);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   localparam logic [63:0] LIM  = pow10(DIGITS);
   localparam logic [63:0] NLIM = pow10(DIGITS - 1);

   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] MINUS = 7'b0111111;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0011000;
         default: g = BLANK;
      endcase
      return g;
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

   state_t               state, state_n;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     bin;
   logic [4*DIGITS-1:0]  bcd;
   logic [4*DIGITS-1:0]  bcd_adj;
   logic [WIDTH-1:0]     val_q;
   logic                 neg_q;
   logic                 ovf_q;
   logic [7*DIGITS-1:0]  disp;
   logic [7*DIGITS-1:0]  fmt;
   logic [7*DIGITS-1:0]  errpat;
   logic                 err;
   logic                 err_q;
   logic                 done_q;
   logic [BW-1:0]        bctr;
   logic                 hidden;
   logic [63:0]          val_ext;
   int                   msd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (load) state_n = SHIFT;
         SHIFT:   if (cnt == CW'(WIDTH - 1)) state_n = FORMAT;
         FORMAT:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++)
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
   end

   // Digits above the most significant non-zero one are blanked; the
   // minus sign takes the first blank slot.
   always_comb begin
      val_ext = {{(64-WIDTH){1'b0}}, val_q};
      msd = 0;
      for (int i = 0; i < DIGITS; i++)
         if (bcd[4*i +: 4] != 4'd0) msd = i;
      fmt = {DIGITS{BLANK}};
      for (int i = 0; i < DIGITS; i++) begin
         if (i <= msd)
            fmt[7*i +: 7] = glyph(bcd[4*i +: 4]);
         else if (neg_q && (val_q != '0) && (i == msd + 1))
            fmt[7*i +: 7] = MINUS;
      end
      errpat = {DIGITS{BLANK}};
      errpat[27:0] = {7'b0000110, 7'b0101111, 7'b0101111, 7'b0100011};
      err = ovf_q || (val_ext >= LIM) || (neg_q && (val_ext >= NLIM));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         bin    <= '0;
         bcd    <= '0;
         val_q  <= '0;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
         disp   <= {DIGITS{BLANK}};
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  val_q <= value;
                  neg_q <= neg;
                  ovf_q <= overflow;
                  bin   <= value;
                  bcd   <= '0;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               bcd <= {bcd_adj[4*DIGITS-2:0], bin[WIDTH-1]};
               bin <= {bin[WIDTH-2:0], 1'b0};
               cnt <= cnt + 1'b1;
            end
            FORMAT: begin
               disp   <= err ? errpat : fmt;
               err_q  <= err;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bctr   <= '0;
         hidden <= 1'b0;
      end else if (state == FORMAT || !(err_q && blink_err)) begin
         bctr   <= '0;
         hidden <= 1'b0;
      end else if (bctr == BW'(BLINK_DIV - 1)) begin
         bctr   <= '0;
         hidden <= ~hidden;
      end else begin
         bctr   <= bctr + 1'b1;
      end
   end

   assign seg  = (hidden && err_q && blink_err) ? {DIGITS{BLANK}} : disp;
   assign busy = (state != IDLE);
   assign done = done_q;

endmodule
